// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and counter helper for the branch predictor
package bp_pkg;

    localparam int BP_INDEX_BITS = 6;
    localparam int BP_PC_BITS    = 32;
    localparam int BP_TAG_BITS   = BP_PC_BITS - BP_INDEX_BITS - 2;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_t;

    typedef struct packed {
        logic                   valid;
        logic [BP_TAG_BITS-1:0] tag;
        logic [BP_PC_BITS-1:0]  target;
        ctr_t                   ctr;
    } btb_entry_t;

    // Saturating 2-bit counter step; the strong states stick
    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        ctr_t n;
        case (c)
            STRONG_NT: n = taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   n = taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    n = taken ? STRONG_T : WEAK_NT;
            default:   n = taken ? STRONG_T : WEAK_T;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/branch_predict_unit_btb_array.sv
// rtl/branch_predict_unit_btb_array.sv - direct-mapped BTB storage, two async read ports, one write port
module btb_array
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = BP_INDEX_BITS
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [INDEX_BITS-1:0] rd_idx_f_i,
    output btb_entry_t            rd_entry_f_o,
    input  logic [INDEX_BITS-1:0] rd_idx_d_i,
    output btb_entry_t            rd_entry_d_o,
    input  logic                  we_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  btb_entry_t            wr_entry_i
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    btb_entry_t tbl_q [ENTRIES];

    // Reads see the table as it stood before this edge; a same-cycle write lands after
    assign rd_entry_f_o = tbl_q[rd_idx_f_i];
    assign rd_entry_d_o = tbl_q[rd_idx_d_i];

    // Async clear of every entry, otherwise a single synchronous write
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK_NT};
            end
        end else if (we_i) begin
            tbl_q[wr_idx_i] <= wr_entry_i;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - F-stage BTB prediction, D-stage resolve/restart, training, perf counters
module branch_predict_unit
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = BP_INDEX_BITS,
    parameter int PC_BITS    = BP_PC_BITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_f,
    input  logic               stall_d,
    input  logic [PC_BITS-1:0] pc_f,
    output logic               pred_taken_f,
    output logic [PC_BITS-1:0] pred_pc_f,
    input  logic               branch_d,
    input  logic               taken_d,
    input  logic [PC_BITS-1:0] pc_d,
    input  logic [PC_BITS-1:0] target_d,
    output logic               restart,
    output logic [PC_BITS-1:0] restart_pc,
    output logic [31:0]        n_branches,
    output logic [31:0]        n_mispredicts
);

    localparam int TAG_BITS = PC_BITS - INDEX_BITS - 2;

    logic [INDEX_BITS-1:0] idx_f;
    logic [INDEX_BITS-1:0] idx_d;
    logic [TAG_BITS-1:0]   tag_f;
    logic [TAG_BITS-1:0]   tag_d;
    btb_entry_t            rd_f;
    btb_entry_t            rd_d;
    logic                  hit_f;
    logic                  hit_d;
    logic                  we;
    btb_entry_t            wr_entry;

    logic                  pred_taken_d_q;
    logic                  pred_taken_d_d;
    logic [PC_BITS-1:0]    pred_target_d_q;
    logic [PC_BITS-1:0]    pred_target_d_d;
    logic [31:0]           n_branches_q;
    logic [31:0]           n_branches_d;
    logic [31:0]           n_mispredicts_q;
    logic [31:0]           n_mispredicts_d;

    logic                  resolve_en;
    logic                  mispredict;

    assign idx_f = pc_f[INDEX_BITS+1:2];
    assign tag_f = pc_f[PC_BITS-1:INDEX_BITS+2];
    assign idx_d = pc_d[INDEX_BITS+1:2];
    assign tag_d = pc_d[PC_BITS-1:INDEX_BITS+2];

    btb_array #(
        .INDEX_BITS (INDEX_BITS)
    ) u_btb (
        .clk_i        (clk),
        .rst_i        (reset),
        .rd_idx_f_i   (idx_f),
        .rd_entry_f_o (rd_f),
        .rd_idx_d_i   (idx_d),
        .rd_entry_d_o (rd_d),
        .we_i         (we),
        .wr_idx_i     (idx_d),
        .wr_entry_i   (wr_entry)
    );

    // F lookup: predict taken only on a tag hit with a taken-leaning counter
    always_comb begin
        hit_f        = rd_f.valid && (rd_f.tag == tag_f);
        pred_taken_f = hit_f && ((rd_f.ctr == WEAK_T) || (rd_f.ctr == STRONG_T));
        pred_pc_f    = pred_taken_f ? rd_f.target : pc_f + PC_BITS'(4);
    end

    // D resolve: compare the carried prediction with the actual outcome
    always_comb begin
        resolve_en = !stall_d;
        if (branch_d) begin
            mispredict = (taken_d != pred_taken_d_q) ||
                         (taken_d && pred_taken_d_q && (target_d != pred_target_d_q));
        end else begin
            mispredict = pred_taken_d_q;
        end
        // Gated by reset so restart drops the moment reset is raised
        restart    = !reset && resolve_en && mispredict;
        restart_pc = (branch_d && taken_d) ? target_d : pc_d + PC_BITS'(4);
    end

    // Training write: counter/target on hit, allocate on taken miss, drop stale entries
    always_comb begin
        hit_d    = rd_d.valid && (rd_d.tag == tag_d);
        we       = 1'b0;
        wr_entry = '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK_NT};
        if (resolve_en) begin
            if (branch_d) begin
                if (hit_d) begin
                    we              = 1'b1;
                    wr_entry.valid  = 1'b1;
                    wr_entry.tag    = tag_d;
                    wr_entry.target = taken_d ? target_d : rd_d.target;
                    wr_entry.ctr    = ctr_next(rd_d.ctr, taken_d);
                end else if (taken_d) begin
                    we              = 1'b1;
                    wr_entry.valid  = 1'b1;
                    wr_entry.tag    = tag_d;
                    wr_entry.target = target_d;
                    wr_entry.ctr    = WEAK_T;
                end
            end else if (pred_taken_d_q) begin
                we = 1'b1;
            end
        end
    end

    // F->D prediction carry: flush on restart, hold on D stall, bubble when only F stalls
    always_comb begin
        pred_taken_d_d  = pred_taken_d_q;
        pred_target_d_d = pred_target_d_q;
        if (restart) begin
            pred_taken_d_d  = 1'b0;
            pred_target_d_d = '0;
        end else if (!stall_d) begin
            if (stall_f) begin
                pred_taken_d_d  = 1'b0;
                pred_target_d_d = '0;
            end else begin
                pred_taken_d_d  = pred_taken_f;
                pred_target_d_d = rd_f.target;
            end
        end
    end

    // Saturating perf counters
    always_comb begin
        n_branches_d    = n_branches_q;
        n_mispredicts_d = n_mispredicts_q;
        if (resolve_en && branch_d && (n_branches_q != 32'hFFFF_FFFF)) begin
            n_branches_d = n_branches_q + 32'd1;
        end
        if (restart && (n_mispredicts_q != 32'hFFFF_FFFF)) begin
            n_mispredicts_d = n_mispredicts_q + 32'd1;
        end
    end

    // State registers with async reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pred_taken_d_q  <= 1'b0;
            pred_target_d_q <= '0;
            n_branches_q    <= '0;
            n_mispredicts_q <= '0;
        end else begin
            pred_taken_d_q  <= pred_taken_d_d;
            pred_target_d_q <= pred_target_d_d;
            n_branches_q    <= n_branches_d;
            n_mispredicts_q <= n_mispredicts_d;
        end
    end

    assign n_branches    = n_branches_q;
    assign n_mispredicts = n_mispredicts_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - randomized and directed checks against a behavioural predictor model
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_f;
    logic        stall_d;
    logic [31:0] pc_f;
    logic        pred_taken_f;
    logic [31:0] pred_pc_f;
    logic        branch_d;
    logic        taken_d;
    logic [31:0] pc_d;
    logic [31:0] target_d;
    logic        restart;
    logic [31:0] restart_pc;
    logic [31:0] n_branches;
    logic [31:0] n_mispredicts;

    always #5 clk = ~clk;

    branch_predict_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall_f       (stall_f),
        .stall_d       (stall_d),
        .pc_f          (pc_f),
        .pred_taken_f  (pred_taken_f),
        .pred_pc_f     (pred_pc_f),
        .branch_d      (branch_d),
        .taken_d       (taken_d),
        .pc_d          (pc_d),
        .target_d      (target_d),
        .restart       (restart),
        .restart_pc    (restart_pc),
        .n_branches    (n_branches),
        .n_mispredicts (n_mispredicts)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Behavioural model: 64-entry table, counters as integers 0..3 (>=2 predicts taken)
    bit          m_valid [64];
    logic [31:0] m_tag   [64];
    logic [31:0] m_target[64];
    int          m_ctr   [64];
    bit          m_pd_taken;
    logic [31:0] m_pd_target;
    logic [31:0] m_nbr;
    logic [31:0] m_nmis;

    // Expectations and inputs of the current cycle
    bit          e_pt;
    logic [31:0] e_ppc;
    bit          e_restart;
    logic [31:0] e_rpc;
    bit          s_br, s_tk, s_stl;
    logic [31:0] s_pcd, s_tgt;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc >> 8;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i]  = 0;
            m_tag[i]    = '0;
            m_target[i] = '0;
            m_ctr[i]    = 1;
        end
        m_pd_taken  = 0;
        m_pd_target = '0;
        m_nbr       = '0;
        m_nmis      = '0;
    endtask

    // Drive one cycle's inputs (called in the low phase), then check combinational outputs
    task automatic apply(input logic [31:0] pcf, input bit br, input bit tk,
                         input logic [31:0] pcd, input logic [31:0] tgt, input bit stl);
        int i;
        bit hit;
        pc_f     = pcf;
        branch_d = br;
        taken_d  = br & tk;
        pc_d     = pcd;
        target_d = tgt;
        stall_f  = stl;
        stall_d  = stl;
        s_br = br; s_tk = br & tk; s_pcd = pcd; s_tgt = tgt; s_stl = stl;
        #1;
        i     = idx_of(pcf);
        hit   = m_valid[i] && (m_tag[i] == tag_of(pcf));
        e_pt  = hit && (m_ctr[i] >= 2);
        e_ppc = e_pt ? m_target[i] : pcf + 32'd4;
        if (stl)
            e_restart = 0;
        else if (br)
            e_restart = (s_tk != m_pd_taken) || (s_tk && m_pd_taken && (tgt != m_pd_target));
        else
            e_restart = m_pd_taken;
        e_rpc = (br && s_tk) ? tgt : pcd + 32'd4;
        check_eq("pred_taken_f", {31'd0, pred_taken_f}, {31'd0, e_pt});
        check_eq("pred_pc_f", pred_pc_f, e_ppc);
        check_eq("restart", {31'd0, restart}, {31'd0, e_restart});
        if (e_restart) check_eq("restart_pc", restart_pc, e_rpc);
        check_eq("n_branches", n_branches, m_nbr);
        check_eq("n_mispredicts", n_mispredicts, m_nmis);
    endtask

    // Clock edge: advance the model with the inputs of the cycle just checked
    task automatic step();
        int i;
        bit hit;
        @(posedge clk);
        if (!s_stl) begin
            i   = idx_of(s_pcd);
            hit = m_valid[i] && (m_tag[i] == tag_of(s_pcd));
            if (s_br) begin
                if (m_nbr != 32'hFFFF_FFFF) m_nbr = m_nbr + 1;
                if (hit) begin
                    m_ctr[i] = s_tk ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                                    : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
                    if (s_tk) m_target[i] = s_tgt;
                end else if (s_tk) begin
                    m_valid[i]  = 1;
                    m_tag[i]    = tag_of(s_pcd);
                    m_target[i] = s_tgt;
                    m_ctr[i]    = 2;
                end
            end else if (m_pd_taken) begin
                m_valid[i] = 0;
            end
        end
        if (e_restart && (m_nmis != 32'hFFFF_FFFF)) m_nmis = m_nmis + 1;
        if (e_restart) begin
            m_pd_taken  = 0;
            m_pd_target = '0;
        end else if (!s_stl) begin
            m_pd_taken  = e_pt;
            m_pd_target = e_pt ? e_ppc : '0;
        end
        @(negedge clk);
    endtask

    task automatic cyc(input logic [31:0] pcf, input bit br, input bit tk,
                       input logic [31:0] pcd, input logic [31:0] tgt, input bit stl);
        apply(pcf, br, tk, pcd, tgt, stl);
        step();
    endtask

    logic [31:0] pc_pool [5];
    logic [31:0] tgt_pool[4];

    initial begin
        pc_pool  = '{32'h40, 32'h140, 32'h80, 32'h240, 32'hC4};
        tgt_pool = '{32'h20, 32'h100, 32'h200, 32'h3C0};
        reset = 1'b1;
        pc_f = '0; pc_d = '0; target_d = '0;
        branch_d = 0; taken_d = 0; stall_f = 0; stall_d = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        cyc(32'h40, 0, 0, 32'h3C, 0, 0);
        check_eq("reset_nbr", n_branches, 32'd0);

        // Loop branch at 0x40 -> 0x20, taken four times
        for (int k = 0; k < 4; k++) begin
            cyc(32'h40, 0, 0, 32'h3C, 0, 0);
            apply(32'h20, 1, 1, 32'h40, 32'h20, 0);
            if (k == 0) check_eq("t1_first_restart_pc", restart_pc, 32'h20);
            else        check_eq("t1_no_restart", {31'd0, restart}, 32'd0);
            step();
        end
        apply(32'h40, 0, 0, 32'h3C, 0, 0);
        check_eq("t1_pred_pc", pred_pc_f, 32'h20);
        step();

        // Same branch falls through twice
        for (int k = 0; k < 2; k++) begin
            apply(32'h44, 1, 0, 32'h40, 32'h20, 0);
            check_eq("t2_restart_pc", restart_pc, 32'h44);
            step();
            cyc(32'h40, 0, 0, 32'h3C, 0, 0);
        end

        // Branch held in D by a stall for two cycles
        cyc(32'h44, 1, 1, 32'h40, 32'h20, 1);
        cyc(32'h44, 1, 1, 32'h40, 32'h20, 1);
        cyc(32'h44, 1, 1, 32'h40, 32'h20, 0);

        // Write and lookup of the same index in one cycle
        apply(32'h80, 1, 1, 32'h80, 32'h100, 0);
        check_eq("t5_old_entry", {31'd0, pred_taken_f}, 32'd0);
        step();
        apply(32'h80, 0, 0, 32'h7C, 0, 0);
        check_eq("t5_new_entry", pred_pc_f, 32'h100);
        step();

        // Reset while restart is asserted
        for (int k = 0; k < 2; k++) begin
            cyc(32'h40, 0, 0, 32'h3C, 0, 0);
            cyc(32'h20, 1, 1, 32'h40, 32'h20, 0);
        end
        cyc(32'h40, 0, 0, 32'h3C, 0, 0);
        apply(32'h40, 0, 0, 32'h40, 0, 0);
        check_eq("t6_pre_restart", {31'd0, restart}, 32'd1);
        reset = 1'b1;
        #1;
        check_eq("t6_restart", {31'd0, restart}, 32'd0);
        check_eq("t6_pred_taken_f", {31'd0, pred_taken_f}, 32'd0);
        check_eq("t6_nbr", n_branches, 32'd0);
        check_eq("t6_nmis", n_mispredicts, 32'd0);
        reset = 1'b0;
        #1;
        check_eq("t6_fd_cleared", {31'd0, restart}, 32'd0);
        model_reset();
        cyc(32'h40, 0, 0, 32'h40, 0, 0);

        // Aliasing branches 0x40 / 0x140 share one index
        for (int k = 0; k < 6; k++) begin
            logic [31:0] bpc;
            bpc = (k % 2) ? 32'h140 : 32'h40;
            cyc(bpc, 0, 0, bpc - 32'd4, 0, 0);
            apply(32'h300, 1, 1, bpc, 32'h20, 0);
            check_eq("t4_alias_restart", {31'd0, restart}, 32'd1);
            step();
        end

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            cyc(pc_pool[$urandom_range(0, 4)], bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                pc_pool[$urandom_range(0, 4)], tgt_pool[$urandom_range(0, 3)],
                ($urandom_range(0, 4) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
